sound_sequencer: RTL and testbench
==================================

SOUND_SEQUENCER -- requirements
Module: sound_sequencer

Interface
REQ-001 Parameter NOTE_FRAMES, default 6, meaning: number of startOfFrame pulses each note lasts (legal 1..15).
REQ-002 clk  input  1  system clock; all state SHALL update on its rising edge.
REQ-003 resetN  input  1  asynchronous active-low reset.
REQ-004 sound_requests  input  4  one bit per sound id 0..3; single-cycle or level; bit 0 highest priority.
REQ-005 startOfFrame  input  1  one-cycle pulse per video frame; sole timebase for note duration.
REQ-006 mute  input  1  forces audio silent without altering sequencing.
REQ-007 sound_signal  output  4  tone code for the tone decoder, registered.
REQ-008 enable_sound  output  1  gates the sine address counter, registered.
REQ-009 busy  output  1  high in PLAY or GAP.
REQ-010 active_id  output  2  id currently sequenced; holds last value when idle.

Function
REQ-011 Block SHALL keep a 4-bit pending register: pending <= (pending | sound_requests) & ~grant_mask each cycle; a request on the same cycle as its own grant SHALL be consumed, not re-latched.
REQ-012 FSM states SHALL be IDLE, PLAY, GAP.
REQ-013 In IDLE, if (pending | sound_requests) != 0, block SHALL grant the lowest set index and enter PLAY on the next edge with note_idx=0, frame_cnt=0.
REQ-014 Grant latency: request asserted in cycle t while IDLE -> enable_sound=1 and sound_signal=first note in cycle t+1.
REQ-015 Internal fixed melody ROM, 4 notes per id, code 4'hF = end-of-melody: id0 {9,7,5,3}; id1 {12,12,F,F}; id2 {2,4,6,8}; id3 {1,F,F,F}.
REQ-016 In PLAY, frame_cnt SHALL increment on each startOfFrame; on startOfFrame with frame_cnt==NOTE_FRAMES-1, frame_cnt SHALL clear and note_idx SHALL advance.
REQ-017 On advance, if note_idx==3 or next note==4'hF, FSM SHALL enter GAP; otherwise sound_signal SHALL take the next note the following cycle.
REQ-018 In GAP, enable_sound=0, sound_signal=0; FSM SHALL return to IDLE on the next startOfFrame (one silent frame between sounds).
REQ-019 enable_sound SHALL equal (state==PLAY) & ~mute; mute SHALL not stall counters or pending capture.
REQ-020 A request for the active id during PLAY/GAP SHALL set pending and replay after GAP.
REQ-021 startOfFrame coincident with a grant cycle SHALL not count toward the first note.

Reset
REQ-022 On resetN low, asynchronously: state=IDLE, pending=0, note_idx=0, frame_cnt=0, sound_signal=0, enable_sound=0, busy=0, active_id=0.
REQ-023 Reset mid-melody SHALL discard the melody and all pending requests; no sound SHALL resume after release without a new request.

Configuration
REQ-024 Macro SOUND_PREEMPT_EN defined: in PLAY, a pending/incoming id of strictly higher priority than active_id SHALL abort the current melody and restart PLAY with the new id next cycle (no GAP); preempted sound dropped, not re-queued.
REQ-025 SOUND_PREEMPT_EN undefined: no preemption; higher-priority requests wait in pending until IDLE.

Verification (NOTE_FRAMES=2)
REQ-026 Reset, pulse sound_requests=4'b0100 one cycle -> next cycle sound_signal=2, enable_sound=1; tones 2,4,6,8 each for 2 frames, then one frame enable_sound=0, then IDLE, busy=0.
REQ-027 Pulse 4'b0010 -> tone 12 for 4 frames total, GAP at F terminator, active_id=1.
REQ-028 Same-cycle 4'b1001 -> id0 plays {9,7,5,3}, then after GAP id3 plays tone 1 for 2 frames.
REQ-029 During id2 note 1, pulse 4'b0001 -> undefined macro: id2 finishes, then id0; defined: next cycle sound_signal=9, active_id=0, id2 never resumes.
REQ-030 mute=1 during id0 -> enable_sound=0, sound_signal sequence and GAP timing identical to unmuted run.
REQ-031 Assert resetN low mid id0 note 2 with id3 pending -> all outputs 0 immediately; after release, stays IDLE with no request.

Source files
------------

// File: rtl/sound_sequencer.sv
// Priority-arbitrated sound sequencer: plays a fixed 4-note melody per sound id, timed by startOfFrame.
// Define SOUND_PREEMPT_EN to let a higher-priority request abort the melody currently playing.
module sound_sequencer #(
    parameter int unsigned NOTE_FRAMES = 6
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic [3:0] sound_requests,
    input  logic       startOfFrame,
    input  logic       mute,
    output logic [3:0] sound_signal,
    output logic       enable_sound,
    output logic       busy,
    output logic [1:0] active_id
);

    typedef enum logic [1:0] {
        IDLE,
        PLAY,
        GAP
    } state_t;

    localparam logic [3:0] LAST_FRAME = 4'(NOTE_FRAMES - 1);
    localparam logic [3:0] END_NOTE   = 4'hF;

    state_t     state_q, state_d;
    logic [3:0] pending_q, pending_d;
    logic [1:0] note_idx_q, note_idx_d;
    logic [3:0] frame_cnt_q, frame_cnt_d;
    logic [1:0] active_id_q, active_id_d;
    logic [3:0] sound_q, sound_d;
    logic       enable_q, enable_d;
    logic       busy_q, busy_d;

    logic [3:0] req_all;
    logic [3:0] grant_mask;
    logic [1:0] grant_id;
    logic       do_grant;
    logic       preempt;
    logic [3:0] next_note;

    // Melody table, note 0 in the low nibble of each row.
    function automatic logic [3:0] melody(input logic [1:0] id, input logic [1:0] idx);
        logic [15:0] row;
        case (id)
            2'd0:    row = 16'h3579;
            2'd1:    row = 16'hFFCC;
            2'd2:    row = 16'h8642;
            default: row = 16'hFFF1;
        endcase
        return row[{idx, 2'b00} +: 4];
    endfunction

    function automatic logic [1:0] lowest_set(input logic [3:0] v);
        if (v[0])      return 2'd0;
        else if (v[1]) return 2'd1;
        else if (v[2]) return 2'd2;
        else           return 2'd3;
    endfunction

    always_comb begin
        state_d     = state_q;
        note_idx_d  = note_idx_q;
        frame_cnt_d = frame_cnt_q;
        active_id_d = active_id_q;
        grant_mask  = '0;
        do_grant    = 1'b0;
        preempt     = 1'b0;
        req_all     = pending_q | sound_requests;
        grant_id    = lowest_set(req_all);
        next_note   = melody(active_id_q, note_idx_q + 2'd1);

        case (state_q)
            IDLE: do_grant = (req_all != '0);
            PLAY: begin
`ifdef SOUND_PREEMPT_EN
                preempt = (req_all != '0) && (grant_id < active_id_q);
`endif
                if (preempt) begin
                    do_grant = 1'b1;
                end else if (startOfFrame) begin
                    if (frame_cnt_q == LAST_FRAME) begin
                        frame_cnt_d = '0;
                        if (note_idx_q == 2'd3 || next_note == END_NOTE) begin
                            state_d = GAP;
                        end else begin
                            note_idx_d = note_idx_q + 2'd1;
                        end
                    end else begin
                        frame_cnt_d = frame_cnt_q + 4'd1;
                    end
                end
            end
            GAP: if (startOfFrame) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // A grant restarts the melody; a frame pulse on the grant cycle is deliberately ignored.
        if (do_grant) begin
            state_d     = PLAY;
            active_id_d = grant_id;
            note_idx_d  = '0;
            frame_cnt_d = '0;
            grant_mask  = 4'b0001 << grant_id;
        end

        pending_d = req_all & ~grant_mask;

        // Outputs are registered from next-state values so they track state without a cycle of lag.
        busy_d   = (state_d != IDLE);
        enable_d = (state_d == PLAY) & ~mute;
        sound_d  = (state_d == PLAY) ? melody(active_id_d, note_idx_d) : '0;
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q     <= IDLE;
            pending_q   <= '0;
            note_idx_q  <= '0;
            frame_cnt_q <= '0;
            active_id_q <= '0;
            sound_q     <= '0;
            enable_q    <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            note_idx_q  <= note_idx_d;
            frame_cnt_q <= frame_cnt_d;
            active_id_q <= active_id_d;
            sound_q     <= sound_d;
            enable_q    <= enable_d;
            busy_q      <= busy_d;
        end
    end

    assign sound_signal = sound_q;
    assign enable_sound = enable_q;
    assign busy         = busy_q;
    assign active_id    = active_id_q;

endmodule

// File: tb/tb_sound_sequencer.sv
// Directed bench for sound_sequencer with NOTE_FRAMES=2; honours SOUND_PREEMPT_EN when defined.
module tb_sound_sequencer;

    logic       clk = 1'b0;
    logic       resetN;
    logic [3:0] sound_requests;
    logic       startOfFrame;
    logic       mute;
    logic [3:0] sound_signal;
    logic       enable_sound;
    logic       busy;
    logic [1:0] active_id;
    logic [7:0] obs;

    int errors = 0;
    int checks = 0;

    sound_sequencer #(.NOTE_FRAMES(2)) dut (
        .clk            (clk),
        .resetN         (resetN),
        .sound_requests (sound_requests),
        .startOfFrame   (startOfFrame),
        .mute           (mute),
        .sound_signal   (sound_signal),
        .enable_sound   (enable_sound),
        .busy           (busy),
        .active_id      (active_id)
    );

    always #5 clk = ~clk;

    assign obs = {sound_signal, enable_sound, busy, active_id};

    function automatic logic [7:0] ex(input logic [3:0] s, input logic en, input logic b,
                                      input logic [1:0] id);
        return {s, en, b, id};
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic frame();
        startOfFrame = 1'b1;
        cyc();
        startOfFrame = 1'b0;
        cyc();
    endtask

    task automatic pulse(input logic [3:0] req);
        sound_requests = req;
        cyc();
        sound_requests = '0;
    endtask

    task automatic test_reset();
        resetN = 1'b1; sound_requests = '0; startOfFrame = 1'b0; mute = 1'b0;
        #2 resetN = 1'b0;
        #1;
        checks++; if (obs !== 8'h00) begin errors++; $display("FAIL reset_assert: obs=%h expected=%h", obs, 8'h00); end
        cyc(); cyc();
        resetN = 1'b1;
        cyc(); frame();
        checks++; if (obs !== 8'h00) begin errors++; $display("FAIL reset_idle: obs=%h expected=%h", obs, 8'h00); end
    endtask

    // Frame pulse coincident with the grant must not shorten the first note.
    task automatic test_id2();
        logic [3:0] t [4];
        logic [7:0] e;
        t = '{4'd2, 4'd4, 4'd6, 4'd8};
        startOfFrame = 1'b1;
        pulse(4'b0100);
        startOfFrame = 1'b0;
        checks++; if (obs !== ex(4'd2, 1, 1, 2)) begin errors++; $display("FAIL id2_grant: obs=%h expected=%h", obs, ex(4'd2, 1, 1, 2)); end
        for (int n = 0; n < 4; n++) begin
            frame();
            checks++; if (obs !== ex(t[n], 1, 1, 2)) begin errors++; $display("FAIL id2_hold%0d: obs=%h expected=%h", n, obs, ex(t[n], 1, 1, 2)); end
            frame();
            e = (n < 3) ? ex(t[(n + 1) % 4], 1, 1, 2) : ex(4'd0, 0, 1, 2);
            checks++; if (obs !== e) begin errors++; $display("FAIL id2_adv%0d: obs=%h expected=%h", n, obs, e); end
        end
        frame();
        checks++; if (obs !== ex(4'd0, 0, 0, 2)) begin errors++; $display("FAIL id2_idle: obs=%h expected=%h", obs, ex(4'd0, 0, 0, 2)); end
    endtask

    // Re-request of the active id during PLAY replays it after the gap.
    task automatic test_id1_replay();
        logic [7:0] e;
        pulse(4'b0010);
        checks++; if (obs !== ex(4'hC, 1, 1, 1)) begin errors++; $display("FAIL id1_grant: obs=%h expected=%h", obs, ex(4'hC, 1, 1, 1)); end
        pulse(4'b0010);
        for (int r = 0; r < 2; r++) begin
            for (int k = 1; k <= 4; k++) begin
                frame();
                e = (k < 4) ? ex(4'hC, 1, 1, 1) : ex(4'd0, 0, 1, 1);
                checks++; if (obs !== e) begin errors++; $display("FAIL id1_run%0d_f%0d: obs=%h expected=%h", r, k, obs, e); end
            end
            frame();
            e = (r == 0) ? ex(4'hC, 1, 1, 1) : ex(4'd0, 0, 0, 1);
            checks++; if (obs !== e) begin errors++; $display("FAIL id1_after_gap%0d: obs=%h expected=%h", r, obs, e); end
        end
    endtask

    task automatic test_same_cycle();
        logic [3:0] t [4];
        logic [7:0] e;
        t = '{4'd9, 4'd7, 4'd5, 4'd3};
        pulse(4'b1001);
        checks++; if (obs !== ex(4'd9, 1, 1, 0)) begin errors++; $display("FAIL same_grant: obs=%h expected=%h", obs, ex(4'd9, 1, 1, 0)); end
        for (int k = 1; k <= 8; k++) begin
            frame();
            e = (k < 8) ? ex(t[k / 2], 1, 1, 0) : ex(4'd0, 0, 1, 0);
            checks++; if (obs !== e) begin errors++; $display("FAIL same_id0_f%0d: obs=%h expected=%h", k, obs, e); end
        end
        frame();
        checks++; if (obs !== ex(4'd1, 1, 1, 3)) begin errors++; $display("FAIL same_id3_start: obs=%h expected=%h", obs, ex(4'd1, 1, 1, 3)); end
        frame();
        checks++; if (obs !== ex(4'd1, 1, 1, 3)) begin errors++; $display("FAIL same_id3_hold: obs=%h expected=%h", obs, ex(4'd1, 1, 1, 3)); end
        frame();
        checks++; if (obs !== ex(4'd0, 0, 1, 3)) begin errors++; $display("FAIL same_id3_gap: obs=%h expected=%h", obs, ex(4'd0, 0, 1, 3)); end
        frame();
        checks++; if (obs !== ex(4'd0, 0, 0, 3)) begin errors++; $display("FAIL same_idle: obs=%h expected=%h", obs, ex(4'd0, 0, 0, 3)); end
    endtask

    task automatic test_preempt();
        logic [3:0] t [4];
        logic [7:0] e;
        t = '{4'd9, 4'd7, 4'd5, 4'd3};
        pulse(4'b0100);
        frame(); frame();
        checks++; if (obs !== ex(4'd4, 1, 1, 2)) begin errors++; $display("FAIL pre_id2_note1: obs=%h expected=%h", obs, ex(4'd4, 1, 1, 2)); end
        pulse(4'b0001);
`ifdef SOUND_PREEMPT_EN
        checks++; if (obs !== ex(4'd9, 1, 1, 0)) begin errors++; $display("FAIL pre_switch: obs=%h expected=%h", obs, ex(4'd9, 1, 1, 0)); end
`else
        checks++; if (obs !== ex(4'd4, 1, 1, 2)) begin errors++; $display("FAIL pre_nowait: obs=%h expected=%h", obs, ex(4'd4, 1, 1, 2)); end
        for (int k = 1; k <= 6; k++) begin
            frame();
            e = (k < 2) ? ex(4'd4, 1, 1, 2) : (k < 4) ? ex(4'd6, 1, 1, 2) :
                (k < 6) ? ex(4'd8, 1, 1, 2) : ex(4'd0, 0, 1, 2);
            checks++; if (obs !== e) begin errors++; $display("FAIL pre_id2_f%0d: obs=%h expected=%h", k, obs, e); end
        end
        frame();
        checks++; if (obs !== ex(4'd9, 1, 1, 0)) begin errors++; $display("FAIL pre_id0_start: obs=%h expected=%h", obs, ex(4'd9, 1, 1, 0)); end
`endif
        for (int k = 1; k <= 8; k++) begin
            frame();
            e = (k < 8) ? ex(t[k / 2], 1, 1, 0) : ex(4'd0, 0, 1, 0);
            checks++; if (obs !== e) begin errors++; $display("FAIL pre_id0_f%0d: obs=%h expected=%h", k, obs, e); end
        end
        frame(); frame();
        checks++; if (obs !== ex(4'd0, 0, 0, 0)) begin errors++; $display("FAIL pre_idle: obs=%h expected=%h", obs, ex(4'd0, 0, 0, 0)); end
    endtask

    task automatic test_mute();
        logic [3:0] t [4];
        logic [7:0] e;
        t = '{4'd9, 4'd7, 4'd5, 4'd3};
        mute = 1'b1;
        pulse(4'b0001);
        checks++; if (obs !== ex(4'd9, 0, 1, 0)) begin errors++; $display("FAIL mute_grant: obs=%h expected=%h", obs, ex(4'd9, 0, 1, 0)); end
        for (int k = 1; k <= 8; k++) begin
            frame();
            e = (k < 8) ? ex(t[k / 2], 0, 1, 0) : ex(4'd0, 0, 1, 0);
            checks++; if (obs !== e) begin errors++; $display("FAIL mute_f%0d: obs=%h expected=%h", k, obs, e); end
        end
        frame();
        checks++; if (obs !== ex(4'd0, 0, 0, 0)) begin errors++; $display("FAIL mute_idle: obs=%h expected=%h", obs, ex(4'd0, 0, 0, 0)); end
        mute = 1'b0;
    endtask

    task automatic test_reset_mid();
        pulse(4'b0001);
        frame(); frame(); frame(); frame();
        pulse(4'b1000);
        checks++; if (obs !== ex(4'd5, 1, 1, 0)) begin errors++; $display("FAIL rstmid_note2: obs=%h expected=%h", obs, ex(4'd5, 1, 1, 0)); end
        #2 resetN = 1'b0;
        #1;
        checks++; if (obs !== 8'h00) begin errors++; $display("FAIL rstmid_async: obs=%h expected=%h", obs, 8'h00); end
        cyc(); cyc();
        resetN = 1'b1;
        for (int k = 0; k < 3; k++) begin
            frame();
            checks++; if (obs !== 8'h00) begin errors++; $display("FAIL rstmid_quiet%0d: obs=%h expected=%h", k, obs, 8'h00); end
        end
    endtask

    initial begin
        test_reset();
        test_id2();
        test_id1_replay();
        test_same_cycle();
        test_preempt();
        test_mute();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
